// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier, one multiplier bit per clock.
// Operands enter as magnitudes. The sign is applied in a single FIX cycle.
// The product comes out as HI/LO halves, each WIDTH bits.
// Optional build macro MULT_SEQ_EARLY_TERM_EN lets RUN finish as soon as the
// remaining multiplier bits are all zero. Results match the default build.
// Parameter constraints: 4 <= WIDTH <= 64, 2**CNT_W > WIDTH.
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // state | meaning
  // IDLE  | waiting for START; HI/LO hold the last result
  // RUN   | one add/shift step per edge, WIDTH steps in total
  // FIX   | apply sign, load HI/LO, pulse DONE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mult;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_lo;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;
  logic               step_en;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] prod;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Magnitudes are taken only for signed operations.
  // The most negative value maps to 2**(WIDTH-1) as an unsigned WIDTH-bit magnitude.
  assign a_mag = (SIGNED && A[WIDTH-1]) ? -A : A;
  assign b_mag = (SIGNED && B[WIDTH-1]) ? -B : B;

  // The carry out of the add is kept as bit WIDTH. The shift folds it into acc.
  assign sum = {1'b0, acc} + (mult[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_SEQ_EARLY_TERM_EN
  // mult shifts in zeros from the top.
  // Once it reaches zero, every remaining step would only shift.
  logic               mult_zero;
  logic [CNT_W-1:0]   resid;

  assign mult_zero = (mult == '0);
  assign step_en   = (state == S_RUN) && !mult_zero;
  // After cnt steps, {acc, acc_lo} holds the partial product shifted left by
  // (WIDTH - cnt) bits. A final right shift realigns it.
  assign resid     = CNT_W'(WIDTH) - cnt;
  assign raw       = {acc, acc_lo} >> resid;
`else
  assign step_en   = (state == S_RUN);
  assign raw       = {acc, acc_lo};
`endif

  assign prod = neg ? -raw : raw;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. START is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
`ifdef MULT_SEQ_EARLY_TERM_EN
        if (mult_zero || last_iter) begin
          state_nxt = S_FIX;
        end
`else
        if (last_iter) begin
          state_nxt = S_FIX;
        end
`endif
      end
      S_FIX: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs derived from state and the result registers.
  always_comb begin
    BUSY = (state == S_RUN) || (state == S_FIX);
    DONE = done_q;
    HI   = hi_q;
    LO   = lo_q;
  end

  // Working datapath: capture on START, then add/shift while RUN steps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mcand  <= '0;
      mult   <= '0;
      acc    <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else if (state == S_IDLE && START) begin
      mcand  <= a_mag;
      mult   <= b_mag;
      acc    <= '0;
      acc_lo <= '0;
      neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
      cnt    <= '0;
    end else if (step_en) begin
      acc    <= sum[WIDTH:1];
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      mult   <= {1'b0, mult[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers: loaded only in FIX, so HI/LO stay stable during RUN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else if (state == S_FIX) begin
      hi_q   <= prod[2*WIDTH-1:WIDTH];
      lo_q   <= prod[WIDTH-1:0];
      done_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed and random checks of mult_seq at WIDTH=32.
module tb_mult_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        sgn;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  mult_seq #(.WIDTH(32), .CNT_W(7)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SIGNED(sgn),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .HI    (HI),
    .LO    (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Runs one operation from IDLE. lat counts edges after the capture edge until DONE is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat,
                       output logic busy_at_done, output logic held);
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic        got;
    @(posedge CLK); #1;
    A = a; B = b; sgn = s; START = 1'b1;
    hi0 = HI; lo0 = LO;
    @(posedge CLK); #1;
    START = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678; sgn = ~s;
    lat = 0; got = 1'b0; held = 1'b1; hi = '0; lo = '0; busy_at_done = 1'b1;
    while (!got && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
      if (DONE) begin
        got = 1'b1; hi = HI; lo = LO; busy_at_done = BUSY;
      end else if (HI !== hi0 || LO !== lo0) begin
        held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; START = 1'b0; sgn = 1'b0; A = '0; B = '0;
    #12;
    n_checks++;
    if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %0h expected 0", HI); end
    n_checks++;
    if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %0h expected 0", LO); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", DONE); end
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    int          exp_lat;
`ifdef MULT_SEQ_EARLY_TERM_EN
    exp_lat = 15;
`else
    exp_lat = 33;
`endif
    do_op(32'd3781, 32'd7132, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if (hi !== 32'd0) begin n_fail++; $display("FAIL unsigned_hi: got %0h expected 0", hi); end
    n_checks++;
    if (lo !== 32'd26966092) begin n_fail++; $display("FAIL unsigned_lo: got %0d expected 26966092", lo); end
    n_checks++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected %0d", lat, exp_lat); end
    n_checks++;
    if (bd !== 1'b0) begin n_fail++; $display("FAIL busy_in_done: got %b expected 0", bd); end
    n_checks++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL hilo_stable_in_run: got %b expected 1", held); end
    @(posedge CLK); #1;
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", DONE); end
  endtask

  task automatic test_wide();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL max_unsigned: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, hi, lo, lat, bd, held);
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0001) begin
      n_fail++; $display("FAIL neg1_squared: got %h_%h expected 00000000_00000001", hi, lo);
    end
  endtask

  task automatic test_signed();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    do_op(32'hFFFF_FFFE, 32'd5, 1'b1, hi, lo, lat, bd, held);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      n_fail++; $display("FAIL signed_m2x5: got %h_%h expected ffffffff_fffffff6", hi, lo);
    end
    do_op(32'd3781, -32'd7132, 1'b1, hi, lo, lat, bd, held);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'd4268001204) begin
      n_fail++; $display("FAIL signed_neg_b: got %h_%0d expected ffffffff_4268001204", hi, lo);
    end
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, hi, lo, lat, bd, held);
    n_checks++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      n_fail++; $display("FAIL signed_min_sq: got %h_%h expected 40000000_00000000", hi, lo);
    end
  endtask

  task automatic test_start_ignored();
    int          ndone;
    int          first;
    logic [31:0] lo_first;
    int          p2;
    int          exp_lat;
`ifdef MULT_SEQ_EARLY_TERM_EN
    p2 = 10; exp_lat = 15;
`else
    p2 = 20; exp_lat = 33;
`endif
    ndone = 0; first = 0; lo_first = '0;
    @(posedge CLK); #1;
    A = 32'd3781; B = 32'd7132; sgn = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        ndone++;
        if (ndone == 1) begin first = c; lo_first = LO; end
      end
      if (c == 5 || c == p2) begin
        START = 1'b1; A = 32'd5; B = 32'd2;
      end else begin
        START = 1'b0;
      end
    end
    n_checks++;
    if (ndone !== 1) begin n_fail++; $display("FAIL ignored_start_done_count: got %0d expected 1", ndone); end
    n_checks++;
    if (first !== exp_lat) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected %0d", first, exp_lat); end
    n_checks++;
    if (lo_first !== 32'd26966092) begin n_fail++; $display("FAIL ignored_start_lo: got %0d expected 26966092", lo_first); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    int          lat2;
    logic        got;
    int          exp_lat;
`ifdef MULT_SEQ_EARLY_TERM_EN
    exp_lat = 4;
`else
    exp_lat = 33;
`endif
    do_op(32'd100, 32'd200, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if (lo !== 32'd20000) begin n_fail++; $display("FAIL b2b_first_lo: got %0d expected 20000", lo); end
    A = 32'd5; B = 32'd2; sgn = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat2 = 0; got = 1'b0; lo = '0; hi = '0;
    while (!got && lat2 < 200) begin
      @(posedge CLK); #1;
      lat2++;
      if (DONE) begin got = 1'b1; lo = LO; hi = HI; end
    end
    n_checks++;
    if (lat2 !== exp_lat) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat2, exp_lat); end
    n_checks++;
    if ({hi, lo} !== 64'd10) begin n_fail++; $display("FAIL b2b_result: got %h_%h expected 0_a", hi, lo); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    int          ndone;
    @(posedge CLK); #1;
    A = 32'd3781; B = 32'd7132; sgn = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b0;
    #2;
    n_checks++;
    if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL midop_reset_hilo: got %h_%h expected 0_0", HI, LO); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midop_reset_busy: got %b expected 0", BUSY); end
    @(posedge CLK); #1;
    RST = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (DONE) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL midop_reset_no_done: got %0d expected 0", ndone); end
    do_op(32'd7, 32'd6, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if ({hi, lo} !== 64'd42) begin n_fail++; $display("FAIL after_reset_result: got %h_%h expected 0_2a", hi, lo); end
  endtask

  task automatic test_early_term();
    logic [31:0] hi, lo;
    int          lat;
    logic        bd, held;
    int          exp0, exp2;
`ifdef MULT_SEQ_EARLY_TERM_EN
    exp0 = 2; exp2 = 4;
`else
    exp0 = 33; exp2 = 33;
`endif
    do_op(32'd12345, 32'd0, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if (lat !== exp0) begin n_fail++; $display("FAIL bzero_latency: got %0d expected %0d", lat, exp0); end
    n_checks++;
    if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL bzero_result: got %h_%h expected 0_0", hi, lo); end
    do_op(32'd5, 32'd2, 1'b0, hi, lo, lat, bd, held);
    n_checks++;
    if (lat !== exp2) begin n_fail++; $display("FAIL btwo_latency: got %0d expected %0d", lat, exp2); end
    n_checks++;
    if ({hi, lo} !== 64'd10) begin n_fail++; $display("FAIL btwo_result: got %h_%h expected 0_a", hi, lo); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo;
    logic        s, bd, held;
    int          lat;
    logic [63:0] exp;
    longint      sa, sb;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 7 == 0) b = b >> $urandom_range(0, 31);
      if (i % 11 == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp = 64'(sa * sb);
      end else begin
        exp = {32'd0, a} * {32'd0, b};
      end
      do_op(a, b, s, hi, lo, lat, bd, held);
      n_checks++;
      if (lat >= 200 || {hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h s=%b: got %h_%h expected %h (lat %0d)", i, a, b, s, hi, lo, exp, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_wide();
    test_signed();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    test_early_term();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised iterative shift-add multiplier; sequential successor to the 32-bit combinational multiplier.
- Produces a 2*WIDTH-bit product as HI/LO halves.
- Per-operation signed/unsigned mode; START/BUSY/DONE handshake.
- Used by the ALU/datapath where area matters more than latency; one multiplier bit retired per clock.

Parameters:
- WIDTH, 32, operand width in bits (legal 4..64); HI and LO are each WIDTH bits.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK    in   1      clock, rising edge.
- RST    in   1      asynchronous, active-low reset.
- START  in   1      request; sampled only in IDLE.
- SIGNED in   1      1 = two's-complement operands, 0 = unsigned; sampled with START.
- A      in   WIDTH  multiplicand; sampled with START.
- B      in   WIDTH  multiplier; sampled with START.
- BUSY   out  1      high while an operation is in flight (RUN or FIX).
- DONE   out  1      one-cycle pulse; HI/LO valid from that cycle.
- HI     out  WIDTH  upper half of product.
- LO     out  WIDTH  lower half of product.

Behaviour:
- Reset: RST low at any time forces IDLE asynchronously.
  - BUSY=0, DONE=0, HI=0, LO=0; counter and internal registers cleared.
  - An in-flight operation is discarded; no DONE is produced for it.
- States:
  - IDLE: START=1 at edge 0 captures operands and SIGNED and goes to RUN.
    - Capture: |A| into the multiplicand register, |B| into the multiplier register, sign flag = SIGNED & (A[W-1]^B[W-1]).
    - Magnitudes are taken only when SIGNED=1. -2^(W-1) maps to magnitude 2^(W-1), unsigned in WIDTH bits.
  - RUN: on each edge, if multiplier LSB = 1, add the multiplicand into the accumulator (WIDTH+1-bit add, carry kept).
    - Then shift {carry, acc, mult} right by 1 and increment the counter.
    - After the WIDTH-th RUN edge (edge WIDTH), go to FIX.
  - FIX: 2W-bit product = sign flag ? two's-complement negation : unmodified.
    - Loads HI/LO, pulses DONE and returns to IDLE on edge WIDTH+1.
- Latency: DONE is high in the cycle after edge WIDTH+1 (33 cycles for WIDTH=32).
- BUSY is high from after edge 0 through edge WIDTH+1, and low in the DONE cycle.
- HI/LO hold the last result until the next DONE or reset; they do not change during RUN.
- START while BUSY is ignored and not queued.
- START high in the DONE cycle is accepted; the next operation begins back-to-back.
- Operands may change after edge 0 without effect.
- Result equals the exact mathematical product mod 2^(2W), signed or unsigned per the captured SIGNED. No overflow is possible.

Optional Feature:
- Macro: MULT_SEQ_EARLY_TERM_EN.
- Defined: in RUN, if the multiplier register is already 0 at an edge, the edge goes straight to FIX with no add/shift.
  - Remaining iterations are skipped; the product is finalised by a residual shift of (WIDTH - counter) into the accumulator/LO alignment.
  - Results are identical to the non-macro build.
  - B=0 gives DONE after edge 2; B=2 gives DONE after edge 4.
- Undefined: fixed latency of WIDTH+1 edges for every operand.

Test Plan (WIDTH=32):
1. Unsigned A=3781, B=7132, SIGNED=0 -> HI=0, LO=26966092; DONE exactly one cycle, 33 cycles after START; BUSY low in the DONE cycle.
2. Unsigned A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Same operands with SIGNED=1 (-1*-1) -> HI=0, LO=1.
3. Signed cases:
   - A=-2, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF6.
   - A=3781, B=-7132 -> HI=0xFFFFFFFF, LO=4268001204.
   - A=B=0x80000000 -> HI=0x40000000, LO=0.
4. Handshake:
   - START pulsed again at cycles 5 and 20 of an operation -> ignored; single DONE with the first result.
   - START held high in the DONE cycle with A=5, B=2 -> second DONE 33 cycles later, LO=10.
5. Reset: RST low at cycle 10 of an operation -> HI=LO=0, BUSY=0, no DONE. Release and START with A=7, B=6 -> LO=42.
6. With MULT_SEQ_EARLY_TERM_EN: B=0 -> DONE after edge 2, HI=LO=0. A=5, B=2 -> DONE after edge 4, LO=10. Random 1000 signed/unsigned pairs match the reference model with either build.
